// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters, the arbiter and the shared uart_tx:
// per-requester req/data/hold/ack/gnt plus the transmitter d_in/tx_start/tx_done_tick handshake.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] data;
  logic [NREQ-1:0]      hold;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      gnt;
  logic [DBIT-1:0]      d_in;
  logic                 tx_start;
  logic                 tx_done_tick;
  logic                 busy;

  modport master (
    output req, data, hold, tx_done_tick,
    input  ack, gnt, d_in, tx_start, busy
  );

  modport slave (
    input  req, data, hold, tx_done_tick,
    output ack, gnt, d_in, tx_start, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte sources, with packet lock via hold.
// Optional macro UART_ARB_PRIO0_EN: requester 0 wins every IDLE arbitration without moving rr_ptr.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int HOLD_TO = 1023
) (
  input  logic             i_clk,
  input  logic             i_reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(HOLD_TO + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [IW-1:0]   r_rr, w_rr;
  logic [IW-1:0]   r_owner, w_owner, w_sel;
  logic            r_hold, w_hold;
  logic [TW-1:0]   r_timer, w_timer;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [NREQ-1:0] r_ack, w_ack;
  logic [NREQ-1:0] w_onehot;
  logic            r_start, w_start;
  logic            r_busy;
  logic            w_load;
  logic [DBIT-1:0] r_din, w_din;
  logic [IW:0]     w_pick;

  // First set request after ptr, wrapping; MSB of the result flags that one was found.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    int            c;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign w_pick   = rr_pick(bus.req, r_rr);
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

  always_comb begin
    w_state = r_state;
    w_rr    = r_rr;
    w_owner = r_owner;
    w_hold  = r_hold;
    w_timer = r_timer;
    w_gnt   = r_gnt;
    w_ack   = '0;
    w_start = 1'b0;
    w_din   = r_din;
    w_load  = 1'b0;
    w_sel   = r_owner;

    case (r_state)
      ST_IDLE: begin
`ifdef UART_ARB_PRIO0_EN
        if (bus.req[0]) begin
          w_load = 1'b1;
          w_sel  = '0;
        end else
`endif
        if (w_pick[IW]) begin
          w_load = 1'b1;
          w_sel  = w_pick[IW-1:0];
          w_rr   = w_pick[IW-1:0];
        end else begin
          w_load = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.tx_done_tick) begin
          if (r_hold && bus.req[r_owner]) begin
            w_load = 1'b1;
          end else if (r_hold) begin
            w_state = ST_HOLD;
            w_timer = '0;
          end else begin
            w_state = ST_IDLE;
            w_gnt   = '0;
          end
        end else begin
          w_state = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // A request arriving on the expiry cycle still takes the byte.
        if (bus.req[r_owner]) begin
          w_load = 1'b1;
        end else if (r_timer == TW'(HOLD_TO - 1)) begin
          w_state = ST_IDLE;
          w_gnt   = '0;
          w_timer = '0;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_gnt   = '0;
      end
    endcase

    if (w_load) begin
      w_owner = w_sel;
      w_gnt   = w_onehot;
      w_ack   = w_onehot;
      w_start = 1'b1;
      w_din   = bus.data[w_sel*DBIT +: DBIT];
      w_hold  = bus.hold[w_sel];
      w_state = ST_WAIT;
    end else begin
      w_owner = w_owner;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_rr    <= IW'(NREQ - 1);
      r_owner <= '0;
      r_hold  <= 1'b0;
      r_timer <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_din   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_rr    <= w_rr;
      r_owner <= w_owner;
      r_hold  <= w_hold;
      r_timer <= w_timer;
      r_gnt   <= w_gnt;
      r_ack   <= w_ack;
      r_start <= w_start;
      r_din   <= w_din;
      r_busy  <= (w_state != ST_IDLE);
    end
  end

  assign bus.ack      = r_ack;
  assign bus.gnt      = r_gnt;
  assign bus.d_in     = r_din;
  assign bus.tx_start = r_start;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester agents with message queues, a uart_tx latency emulator,
// and an ownership-level reference model compared against the DUT on every cycle.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int DBIT    = 8;
  localparam int HOLD_TO = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .HOLD_TO(HOLD_TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Requester side: each queue entry is {hold, byte}.
  logic [8:0] q [NREQ][$];
  int         gap [NREQ];
  bit         gen_en, gap_en, spur_en;
  int         uart_cnt, lat_fixed;
  int         acks[$];

  // Reference model: who owns the transmitter and why.
  int              m_owner, m_last, m_parked;
  bit              m_wait, m_lock;
  logic [NREQ-1:0] e_gnt, e_ack;
  logic            e_start, e_busy;
  logic [DBIT-1:0] e_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int take;
    e_ack   = '0;
    e_start = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = NREQ - 1; m_wait = 1'b0; m_lock = 1'b0; m_parked = -1;
      e_din = '0; e_gnt = '0; e_busy = 1'b0;
      return;
    end
    take = -1;
    if (m_owner < 0) begin
`ifdef UART_ARB_PRIO0_EN
      if (bus.req[0]) take = 0;
`endif
      if (take < 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (take < 0 && bus.req[(m_last + k) % NREQ]) take = (m_last + k) % NREQ;
        if (take >= 0) m_last = take;
      end
    end else if (m_wait) begin
      if (bus.tx_done_tick) begin
        m_wait = 1'b0;
        if (m_lock && bus.req[m_owner]) take = m_owner;
        else if (m_lock) m_parked = 0;
        else m_owner = -1;
      end
    end else begin
      if (bus.req[m_owner]) take = m_owner;
      else begin
        m_parked++;
        if (m_parked == HOLD_TO) begin
          m_owner = -1; m_parked = -1;
        end
      end
    end
    if (take >= 0) begin
      m_owner = take; m_wait = 1'b1; m_parked = -1; m_lock = bus.hold[take];
      e_ack[take] = 1'b1;
      e_start = 1'b1;
      e_din = bus.data[take*DBIT +: DBIT];
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_busy = (m_owner >= 0);
  endtask

  task automatic drive_uart();
    bus.tx_done_tick = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus.tx_done_tick = 1'b1;
    end else if (spur_en && $urandom_range(0, 15) == 0) begin
      bus.tx_done_tick = 1'b1;
    end
  endtask

  task automatic agent_drive();
    int len;
    for (int i = 0; i < NREQ; i++) begin
      if (gen_en && q[i].size() == 0 && $urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++)
          q[i].push_back({(j < len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
      end
      if (gap[i] > 0) begin
        gap[i]--;
        bus.req[i] = 1'b0;
      end else begin
        bus.req[i] = (q[i].size() > 0);
      end
      if (q[i].size() > 0) begin
        bus.data[i*DBIT +: DBIT] = q[i][0][7:0];
        bus.hold[i] = q[i][0][8];
      end
    end
  endtask

  task automatic agent_observe();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i] === 1'b1) begin
        acks.push_back(i);
        if (q[i].size() > 0) q[i].delete(0);
        if (gap_en && q[i].size() > 0 && $urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 12);
      end
    end
    if (bus.tx_start === 1'b1) uart_cnt = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 6);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_uart();
      agent_drive();
      model_update();
      @(posedge clk);
      @(negedge clk);
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("tx_start", 32'(bus.tx_start), 32'(e_start));
      chk("d_in", 32'(bus.d_in), 32'(e_din));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      agent_observe();
    end
  endtask

  task automatic wait_idle(input int maxc, input string name);
    bit done;
    int tot;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      tot = 0;
      for (int i = 0; i < NREQ; i++) tot += q[i].size();
      if (tot == 0 && bus.busy === 1'b0 && uart_cnt == 0) done = 1'b1;
      else run(1);
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int cnt;
    int exp_t2[8];
    int exp_t3[5];
    rst = 1'b1;
    bus.req = '0; bus.data = '0; bus.hold = '0; bus.tx_done_tick = 1'b0;
    gen_en = 1'b0; gap_en = 1'b0; spur_en = 1'b0; lat_fixed = 0; uart_cnt = 0;
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    @(negedge clk);
    run(2);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_din", 32'(bus.d_in), 32'd0);
    rst = 1'b0;

    // Single byte, transmitter done 10 cycles after tx_start.
    lat_fixed = 10;
    q[0].push_back({1'b0, 8'h41});
    run(1);
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_start", 32'(bus.tx_start), 32'h1);
    chk("t1_din", 32'(bus.d_in), 32'h41);
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    run(9);
    chk("t1_gnt_wait", 32'(bus.gnt), 32'h1);
    chk("t1_busy_wait", 32'(bus.busy), 32'h1);
    run(1);
    chk("t1_gnt_done", 32'(bus.gnt), 32'h0);
    chk("t1_busy_done", 32'(bus.busy), 32'h0);

    // All four requesting continuously.
    lat_fixed = 5;
    acks.delete();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 6; j++) q[i].push_back({1'b0, 8'(8'h30 + i)});
`ifdef UART_ARB_PRIO0_EN
    exp_t2 = '{0, 0, 0, 0, 0, 0, 1, 2};
`else
    exp_t2 = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
    run(60);
    chk("t2_count", 32'(acks.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < acks.size(); k++) chk("t2_order", 32'(acks[k]), 32'(exp_t2[k]));
    wait_idle(400, "t2");

    // Locked three-byte message from 2 while 1 and 3 wait.
    pulse_reset();
    lat_fixed = 3;
    q[1].push_back({1'b0, 8'h41});
    wait_idle(50, "t3a");
    acks.delete();
    q[2].push_back({1'b1, 8'h2D});
    q[2].push_back({1'b1, 8'h31});
    q[2].push_back({1'b0, 8'h32});
    q[1].push_back({1'b0, 8'h42});
    q[3].push_back({1'b0, 8'h43});
    wait_idle(200, "t3");
    exp_t3 = '{2, 2, 2, 3, 1};
    chk("t3_count", 32'(acks.size()), 32'd5);
    for (int k = 0; k < 5 && k < acks.size(); k++) chk("t3_order", 32'(acks[k]), 32'(exp_t3[k]));

    // Locked owner goes quiet; grant held HOLD_TO cycles, then 3 gets it.
    pulse_reset();
    q[0].push_back({1'b1, 8'h78});
    run(1);
    chk("t4_ack0", 32'(bus.ack), 32'h1);
    q[3].push_back({1'b0, 8'h79});
    cnt = 0;
    while (bus.tx_done_tick !== 1'b1 && cnt < 20) begin
      run(1);
      cnt++;
    end
    chk("t4_tick_seen", 32'(bus.tx_done_tick), 32'd1);
    cnt = 0;
    for (int k = 0; k < 20 && bus.gnt === 4'b0001; k++) begin
      cnt++;
      run(1);
    end
    chk("t4_hold_cycles", 32'(cnt), 32'(HOLD_TO));
    chk("t4_released", 32'(bus.gnt), 32'h0);
    run(1);
    chk("t4_ack3", 32'(bus.ack), 32'h8);
    chk("t4_gnt3", 32'(bus.gnt), 32'h8);
    wait_idle(50, "t4");

    // Reset while WAIT; stale tick two cycles later must be ignored.
    q[1].push_back({1'b0, 8'h7A});
    run(1);
    chk("t5_ack", 32'(bus.ack), 32'h2);
    pulse_reset();
    acks.delete();
    run(4);
    chk("t5_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_start", 32'(bus.tx_start), 32'h0);
    chk("t5_din", 32'(bus.d_in), 32'h0);
    chk("t5_no_ack", 32'(acks.size()), 32'd0);

    // Requester 0 granted last, then 0 and 1 together.
    q[0].push_back({1'b0, 8'h70});
    wait_idle(50, "t6a");
    q[0].push_back({1'b0, 8'h71});
    q[1].push_back({1'b0, 8'h72});
    run(1);
`ifdef UART_ARB_PRIO0_EN
    chk("t6_winner", 32'(bus.ack), 32'h1);
`else
    chk("t6_winner", 32'(bus.ack), 32'h2);
`endif
    wait_idle(100, "t6");

    // Random traffic: messages, pauses inside locks, varying latency, stray ticks.
    lat_fixed = 0;
    gen_en = 1'b1; gap_en = 1'b1; spur_en = 1'b1;
    run(3000);
    gen_en = 1'b0; gap_en = 1'b0; spur_en = 1'b0;
    wait_idle(3000, "rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
